// File: rtl/barrel_shift_pipelined.sv
// Pipelined barrel shifter: one register stage per shift-amount bit.
// Supports LSL/LSR/ASR/ROR; valid/ready on both sides with a global stall.
module barrel_shift_pipelined #(
    parameter  int unsigned N  = 8,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arg_vld,
    output logic          arg_rdy,
    input  logic [N-1:0]  arg_data,
    input  logic [SW-1:0] arg_shamt,
    input  logic [1:0]    arg_mode,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [N-1:0]  res_data
);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    logic          en_c;

    logic          vld_q   [SW];
    logic          vld_d   [SW];
    logic [N-1:0]  data_q  [SW];
    logic [N-1:0]  data_d  [SW];
    logic [SW-1:0] shamt_q [SW];
    logic [SW-1:0] shamt_d [SW];
    logic [1:0]    mode_q  [SW];
    logic [1:0]    mode_d  [SW];
    logic          sign_q  [SW];
    logic          sign_d  [SW];

    // Inputs seen by each stage: stage 0 takes the operand, stage k takes stage k-1.
    logic          src_vld   [SW];
    logic [N-1:0]  src_data  [SW];
    logic [SW-1:0] src_shamt [SW];
    logic [1:0]    src_mode  [SW];
    logic          src_sign  [SW];

    // Single fixed-distance shift step; amt is always < N.
    function automatic logic [N-1:0] shift_by(
        input logic [N-1:0] d,
        input logic [1:0]   mode,
        input logic         sign,
        input int unsigned  amt
    );
        logic [N-1:0] ones;
        logic [N-1:0] res;
        ones = '1;
        case (mode)
            MODE_LSL: res = d << amt;
            MODE_LSR: res = d >> amt;
            MODE_ASR: res = (d >> amt) | (sign ? ~(ones >> amt) : '0);
            default:  res = (d >> amt) | (d << (N - amt));
        endcase
        return res;
    endfunction

    assign en_c     = !res_vld || res_rdy;
    assign arg_rdy  = en_c;
    assign res_vld  = vld_q[SW-1];
    assign res_data = data_q[SW-1];

    assign src_vld[0]   = arg_vld;
    assign src_data[0]  = arg_data;
    assign src_shamt[0] = arg_shamt;
    assign src_mode[0]  = arg_mode;
    assign src_sign[0]  = arg_data[N-1];

    for (genvar k = 1; k < SW; k++) begin : g_link
        assign src_vld[k]   = vld_q[k-1];
        assign src_data[k]  = data_q[k-1];
        assign src_shamt[k] = shamt_q[k-1];
        assign src_mode[k]  = mode_q[k-1];
        assign src_sign[k]  = sign_q[k-1];
    end

    // Next state: hold everything on stall, otherwise each stage applies its 2^k step.
    always_comb begin
        vld_d   = vld_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        sign_d  = sign_q;
        if (en_c) begin
            for (int k = 0; k < SW; k++) begin
                vld_d[k]   = src_vld[k];
                shamt_d[k] = src_shamt[k];
                mode_d[k]  = src_mode[k];
                sign_d[k]  = src_sign[k];
                data_d[k]  = src_shamt[k][k]
                           ? shift_by(src_data[k], src_mode[k], src_sign[k], 32'd1 << k)
                           : src_data[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SW; k++) begin
                vld_q[k]   <= 1'b0;
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                mode_q[k]  <= '0;
                sign_q[k]  <= 1'b0;
            end
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
        end
    end

endmodule

// File: tb/tb_barrel_shift_pipelined.sv
// Directed bench for barrel_shift_pipelined (N = 8, latency 3).
module tb_barrel_shift_pipelined;

    logic       clk;
    logic       rst;
    logic       arg_vld;
    logic       arg_rdy;
    logic [7:0] arg_data;
    logic [2:0] arg_shamt;
    logic [1:0] arg_mode;
    logic       res_vld;
    logic       res_rdy;
    logic [7:0] res_data;

    int tests;
    int fails;

    barrel_shift_pipelined #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .arg_vld   (arg_vld),
        .arg_rdy   (arg_rdy),
        .arg_data  (arg_data),
        .arg_shamt (arg_shamt),
        .arg_mode  (arg_mode),
        .res_vld   (res_vld),
        .res_rdy   (res_rdy),
        .res_data  (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ref_shift(input logic [7:0] a, input logic [2:0] s,
                                             input logic [1:0] m);
        logic [15:0]       rr;
        logic signed [7:0] sa;
        logic signed [7:0] sr;
        rr = {a, a} >> s;
        sa = a;
        sr = sa >>> s;
        case (m)
            2'd0:    return a << s;
            2'd1:    return a >> s;
            2'd2:    return sr;
            default: return rr[7:0];
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            arg_vld = 1'b0;
            res_rdy = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arg_vld = 1'b0; arg_data = '0; arg_shamt = '0; arg_mode = '0; res_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (res_vld !== 1'b0) begin fails++; $display("FAIL reset_res_vld got %b want 0", res_vld); end
        tests++;
        if (res_data !== 8'h00) begin fails++; $display("FAIL reset_res_data got %h want 00", res_data); end
        tests++;
        if (arg_rdy !== 1'b1) begin fails++; $display("FAIL reset_arg_rdy got %b want 1", arg_rdy); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // 0x96 shifted by 3 in every mode, with exact latency check.
    task automatic test_modes();
        logic [7:0] exp_v [4];
        exp_v = '{8'hB0, 8'h12, 8'hF2, 8'hD2};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            arg_vld = 1'b1; arg_data = 8'h96; arg_shamt = 3'd3; arg_mode = 2'(i);
            @(posedge clk); #1;
            arg_vld = 1'b0;
            for (int c = 0; c < 3; c++) begin
                tests++;
                if (res_vld !== (c == 2)) begin
                    fails++;
                    $display("FAIL modes_latency mode %0d cyc %0d res_vld got %b want %b", i, c, res_vld, c == 2);
                end
                if (c < 2) begin @(posedge clk); #1; end
            end
            tests++;
            if (res_data !== exp_v[i]) begin
                fails++;
                $display("FAIL modes_data mode %0d got %h want %h", i, res_data, exp_v[i]);
            end
        end
        idle(3);
    endtask

    task automatic test_boundaries();
        logic [2:0] sh [8];
        logic [7:0] exp_v [8];
        sh    = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7};
        exp_v = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h80, 8'h01, 8'hFF, 8'h03};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            arg_vld = 1'b1; arg_data = 8'h81; arg_shamt = sh[i]; arg_mode = 2'(i % 4);
            @(posedge clk); #1;
            arg_vld = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            tests++;
            if (res_vld !== 1'b1 || res_data !== exp_v[i]) begin
                fails++;
                $display("FAIL boundary shamt %0d mode %0d got vld %b data %h want 1 %h",
                         sh[i], i % 4, res_vld, res_data, exp_v[i]);
            end
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [7:0] q [$];
        logic [7:0] a;
        logic [2:0] s;
        logic [1:0] m;
        int         got;
        got = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (c < 16) begin
                a = 8'($urandom); s = 3'($urandom_range(0, 7)); m = 2'($urandom_range(0, 3));
                arg_vld = 1'b1; arg_data = a; arg_shamt = s; arg_mode = m;
                q.push_back(ref_shift(a, s, m));
            end else begin
                arg_vld = 1'b0;
            end
            @(posedge clk); #1;
            tests++;
            if (res_vld !== (c >= 2 && c < 18)) begin
                fails++;
                $display("FAIL b2b_vld cyc %0d got %b want %b", c, res_vld, c >= 2 && c < 18);
            end
            if (res_vld === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_extra cyc %0d got %h want none", c, res_data);
                end else if (res_data !== q[0]) begin
                    fails++;
                    $display("FAIL b2b_data cyc %0d got %h want %h", c, res_data, q[0]);
                end
                if (q.size() > 0) begin void'(q.pop_front()); got++; end
            end
        end
        tests++;
        if (got != 16) begin fails++; $display("FAIL b2b_count got %0d want 16", got); end
        idle(2);
    endtask

    task automatic test_stall();
        logic [7:0] d [4];
        logic [2:0] s [4];
        logic [1:0] m [4];
        logic [7:0] q [$];
        logic       acc;
        logic       xfer;
        int         idx;
        int         popped;
        d = '{8'hC3, 8'h5A, 8'h81, 8'h7E};
        s = '{3'd1, 3'd2, 3'd5, 3'd4};
        m = '{2'd2, 2'd3, 2'd0, 2'd1};
        idx = 0; popped = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            res_rdy = !(c >= 3 && c < 8);
            arg_vld = (idx < 4);
            if (idx < 4) begin arg_data = d[idx]; arg_shamt = s[idx]; arg_mode = m[idx]; end
            #1;
            acc  = arg_vld && arg_rdy;
            xfer = res_vld && res_rdy;
            @(posedge clk);
            if (xfer) begin
                if (q.size() > 0) void'(q.pop_front());
                popped++;
            end
            if (acc) begin
                q.push_back(ref_shift(d[idx], s[idx], m[idx]));
                idx++;
            end
            #1;
            if (c >= 3 && c < 8) begin
                tests++;
                if (arg_rdy !== 1'b0 || res_vld !== 1'b1 || res_data !== 8'hE1) begin
                    fails++;
                    $display("FAIL stall_hold cyc %0d got rdy %b vld %b data %h want 0 1 e1",
                             c, arg_rdy, res_vld, res_data);
                end
            end
            if (res_vld === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL stall_extra cyc %0d got %h want none", c, res_data);
                end else if (res_data !== q[0]) begin
                    fails++;
                    $display("FAIL stall_order cyc %0d got %h want %h", c, res_data, q[0]);
                end
            end
        end
        tests++;
        if (popped != 4 || q.size() != 0 || res_vld !== 1'b0) begin
            fails++;
            $display("FAIL stall_drain got popped %0d left %0d vld %b want 4 0 0", popped, q.size(), res_vld);
        end
        idle(2);
    endtask

    task automatic test_alternate();
        logic       hist [12];
        logic       exp_vld;
        logic [7:0] q [$];
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            hist[c]   = (c < 8) && (c % 2 == 0);
            arg_vld   = hist[c];
            arg_data  = 8'(8'h13 * (c + 1));
            arg_shamt = 3'(c + 1);
            arg_mode  = 2'(c / 2);
            if (hist[c]) q.push_back(ref_shift(arg_data, arg_shamt, arg_mode));
            @(posedge clk); #1;
            exp_vld = (c >= 2) ? hist[c-2] : 1'b0;
            tests++;
            if (res_vld !== exp_vld) begin
                fails++;
                $display("FAIL alt_vld cyc %0d got %b want %b", c, res_vld, exp_vld);
            end
            if (res_vld === 1'b1 && q.size() > 0) begin
                tests++;
                if (res_data !== q[0]) begin
                    fails++;
                    $display("FAIL alt_data cyc %0d got %h want %h", c, res_data, q[0]);
                end
                void'(q.pop_front());
            end
        end
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL alt_lost got %0d left want 0", q.size()); end
        idle(2);
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            arg_vld = 1'b1; arg_data = 8'hF0 | 8'(c + 1); arg_shamt = 3'd1; arg_mode = 2'd1;
            @(posedge clk);
        end
        #1;
        arg_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (res_vld !== 1'b0 || res_data !== 8'h00 || arg_rdy !== 1'b1) begin
            fails++;
            $display("FAIL midreset got vld %b data %h rdy %b want 0 00 1", res_vld, res_data, arg_rdy);
        end
        @(negedge clk);
        rst = 1'b0;
        arg_vld = 1'b1; arg_data = 8'h96; arg_shamt = 3'd3; arg_mode = 2'd3;
        @(posedge clk); #1;
        arg_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tests++;
            if (res_vld !== (c == 2)) begin
                fails++;
                $display("FAIL post_reset_vld cyc %0d got %b want %b", c, res_vld, c == 2);
            end
            if (c < 2) begin @(posedge clk); #1; end
        end
        tests++;
        if (res_data !== 8'hD2) begin
            fails++;
            $display("FAIL post_reset_data got %h want d2", res_data);
        end
        idle(3);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_modes();
        test_boundaries();
        test_back_to_back();
        test_stall();
        test_alternate();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
